// File: rtl/nanorv32_irq_stim.sv
// Interrupt stimulus generator: NUM_CH down-counter channels drive irq[BASE_IRQ+i],
// each in one-cycle pulse or level-until-ack mode, with runtime reconfiguration.
module nanorv32_irq_stim #(
    parameter int                          IRQ_W       = 32,
    parameter int                          NUM_CH      = 2,
    parameter int                          CNT_W       = 16,
    parameter int                          BASE_IRQ    = 4,
    parameter logic [NUM_CH*CNT_W-1:0]     PERIOD_INIT = {16'd65535, 16'd8191},
    parameter logic [NUM_CH-1:0]           MODE_INIT   = '0,
    parameter logic [NUM_CH-1:0]           EN_INIT     = '1,
    localparam int                         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [CNT_W-1:0]     cfg_period,
    input  logic                 cfg_mode,
    input  logic                 cfg_en,
    input  logic [IRQ_W-1:0]     irq_ack,
    output logic [IRQ_W-1:0]     irq,
    output logic [NUM_CH-1:0]    overrun
);

    if ((NUM_CH < 1) || (BASE_IRQ < 0) || (BASE_IRQ + NUM_CH > IRQ_W)) begin : g_param_err
        $error("nanorv32_irq_stim: channel range does not fit inside the irq bus");
    end

    logic [NUM_CH-1:0] pendVec;
    logic [NUM_CH-1:0] ovrVec;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(i);

        logic [CNT_W-1:0] period_q, period_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             mode_q, mode_d;
        logic             en_q, en_d;
        logic             pend_q, pend_d;
        logic             ovr_q, ovr_d;
        logic             cfgHit;
        logic             expire;
        logic             ackHit;

        // Out-of-range channel numbers match no IDX, so such writes fall through untouched.
        assign cfgHit = cfg_we && (cfg_ch == IDX);
        assign expire = en_q && (cnt_q == '0);
        assign ackHit = irq_ack[BASE_IRQ+i];

        always_comb begin
            period_d = period_q;
            cnt_d    = cnt_q;
            mode_d   = mode_q;
            en_d     = en_q;
            pend_d   = pend_q;
            ovr_d    = ovr_q;
            if (cfgHit) begin
                period_d = cfg_period;
                cnt_d    = cfg_period;
                mode_d   = cfg_mode;
                en_d     = cfg_en;
                pend_d   = 1'b0;
                ovr_d    = 1'b0;
            end else if (!en_q) begin
                pend_d = 1'b0;
            end else begin
                cnt_d = expire ? period_q : (cnt_q - 1'b1);
                if (!mode_q) begin
                    pend_d = expire;
                end else begin
                    // A fresh expire beats a simultaneous ack; only an unacked repeat is an overrun.
                    if (expire && pend_q && !ackHit) begin
                        ovr_d = 1'b1;
                    end
                    pend_d = expire || (pend_q && !ackHit);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                period_q <= PERIOD_INIT[i*CNT_W +: CNT_W];
                cnt_q    <= PERIOD_INIT[i*CNT_W +: CNT_W];
                mode_q   <= MODE_INIT[i];
                en_q     <= EN_INIT[i];
                pend_q   <= 1'b0;
                ovr_q    <= 1'b0;
            end else begin
                period_q <= period_d;
                cnt_q    <= cnt_d;
                mode_q   <= mode_d;
                en_q     <= en_d;
                pend_q   <= pend_d;
                ovr_q    <= ovr_d;
            end
        end

        assign pendVec[i] = pend_q;
        assign ovrVec[i]  = ovr_q;
    end

    assign irq     = IRQ_W'(pendVec) << BASE_IRQ;
    assign overrun = ovrVec;

endmodule

// File: tb/tb_nanorv32_irq_stim.sv
// Directed bench for nanorv32_irq_stim; a second small instance exercises an out-of-range channel write.
module tb_nanorv32_irq_stim;

    logic        clk;
    logic        reset;
    logic        cfgWe;
    logic        cfgCh;
    logic [15:0] cfgPeriod;
    logic        cfgMode;
    logic        cfgEn;
    logic [31:0] irqAck;
    logic [31:0] irq;
    logic [1:0]  overrun;

    logic        cfg3We;
    logic [1:0]  cfg3Ch;
    logic [7:0]  cfg3Period;
    logic        cfg3Mode;
    logic        cfg3En;
    logic [7:0]  irq3Ack;
    logic [7:0]  irq3;
    logic [2:0]  overrun3;

    int checkCount = 0;
    int passCount  = 0;
    int edgeNum    = 0;
    int w          = 0;
    int highCount  = 0;
    logic [7:0] exp3;

    nanorv32_irq_stim dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfgWe),
        .cfg_ch     (cfgCh),
        .cfg_period (cfgPeriod),
        .cfg_mode   (cfgMode),
        .cfg_en     (cfgEn),
        .irq_ack    (irqAck),
        .irq        (irq),
        .overrun    (overrun)
    );

    nanorv32_irq_stim #(
        .IRQ_W       (8),
        .NUM_CH      (3),
        .CNT_W       (8),
        .BASE_IRQ    (1),
        .PERIOD_INIT ({8'd4, 8'd3, 8'd2}),
        .MODE_INIT   (3'b000),
        .EN_INIT     (3'b111)
    ) dut3 (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg3We),
        .cfg_ch     (cfg3Ch),
        .cfg_period (cfg3Period),
        .cfg_mode   (cfg3Mode),
        .cfg_en     (cfg3En),
        .irq_ack    (irq3Ack),
        .irq        (irq3),
        .overrun    (overrun3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic we, input logic ch, input logic [15:0] period,
                                 input logic mode, input logic en);
        cfgWe     = we;
        cfgCh     = ch;
        cfgPeriod = period;
        cfgMode   = mode;
        cfgEn     = en;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h (edge %0d)", tag, observed, expected, edgeNum);
    endtask

    // Advance to just after the given edge number (edge 1 = first edge after reset release).
    task automatic stepTo(input int target);
        while (edgeNum < target) begin
            @(posedge clk);
            edgeNum++;
        end
        #1;
    endtask

    task automatic writeCfg(input logic ch, input logic [15:0] period, input logic mode, input logic en);
        applyStimulus(1'b1, ch, period, mode, en);
        stepTo(edgeNum + 1);
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        w = edgeNum;
    endtask

    initial begin
        reset      = 1'b1;
        irqAck     = '0;
        cfg3We     = 1'b0;
        cfg3Ch     = '0;
        cfg3Period = '0;
        cfg3Mode   = 1'b0;
        cfg3En     = 1'b0;
        irq3Ack    = '0;
        applyStimulus(1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_irq", irq, 32'h0);
        checkOutput("rst_ovr", 32'(overrun), 32'h0);
        reset   = 1'b0;
        edgeNum = 0;

        // Default periods: ch0 every 8192 edges, ch1 every 65536 edges, pulse mode
        stepTo(8191);  checkOutput("def_8191", irq, 32'h0);
        stepTo(8192);  checkOutput("def_8192", irq, 32'h10);
        stepTo(8193);  checkOutput("def_8193", irq, 32'h0);
        stepTo(16384); checkOutput("def_16384", irq, 32'h10);
        stepTo(65535); checkOutput("def_65535", irq, 32'h0);
        stepTo(65536); checkOutput("def_65536", irq, 32'h30);
        stepTo(65537); checkOutput("def_65537", irq, 32'h0);

        // ch0 pulse with P=3, ack on its bit must be ignored
        writeCfg(1'b0, 16'd3, 1'b0, 1'b1);
        irqAck = 32'h10;
        stepTo(w + 3);  checkOutput("p3_w3", irq, 32'h0);
        stepTo(w + 4);  checkOutput("p3_w4", irq, 32'h10);
        stepTo(w + 5);  checkOutput("p3_w5", irq, 32'h0);
        stepTo(w + 8);  checkOutput("p3_w8", irq, 32'h10);
        stepTo(w + 12); checkOutput("p3_w12", irq, 32'h10);
        irqAck = '0;

        // P=0 holds the pulse line high continuously
        writeCfg(1'b0, 16'd0, 1'b0, 1'b1);
        checkOutput("p0_w0", irq, 32'h0);
        stepTo(w + 1); checkOutput("p0_w1", irq, 32'h10);
        stepTo(w + 6); checkOutput("p0_w6", irq, 32'h10);

        // Disable ch0: line drops next cycle and stays quiet
        writeCfg(1'b0, 16'd5, 1'b0, 1'b0);
        checkOutput("dis_w0", irq, 32'h0);
        highCount = 0;
        for (int k = 0; k < 100; k++) begin
            stepTo(edgeNum + 1);
            if (irq[4]) highCount++;
        end
        checkOutput("dis_quiet", 32'(highCount), 32'h0);

        // ch1 level P=9, no ack: rise at W+10, overrun at W+20
        writeCfg(1'b1, 16'd9, 1'b1, 1'b1);
        stepTo(w + 9);  checkOutput("lvl_w9", irq, 32'h0);
        stepTo(w + 10); checkOutput("lvl_w10", irq, 32'h20);
        stepTo(w + 15); checkOutput("lvl_w15", irq, 32'h20);
        stepTo(w + 19); checkOutput("lvl_ovr_w19", 32'(overrun), 32'h0);
        stepTo(w + 20); checkOutput("lvl_ovr_w20", 32'(overrun), 32'h2);
        checkOutput("lvl_irq_w20", irq, 32'h20);

        writeCfg(1'b1, 16'd9, 1'b1, 1'b1);
        checkOutput("clr_irq", irq, 32'h0);
        checkOutput("clr_ovr", 32'(overrun), 32'h0);

        // Ack coinciding with the second expire, then a lone ack
        stepTo(w + 10); checkOutput("ack_w10", irq, 32'h20);
        stepTo(w + 19);
        irqAck = 32'h20;
        stepTo(w + 20);
        irqAck = '0;
        checkOutput("ack_same_irq", irq, 32'h20);
        checkOutput("ack_same_ovr", 32'(overrun), 32'h0);
        stepTo(w + 24);
        irqAck = 32'h20;
        stepTo(w + 25);
        irqAck = '0;
        checkOutput("ack_lone", irq, 32'h0);

        // Build pending + overrun, then reset mid-operation
        stepTo(w + 30); checkOutput("pre_rst_irq", irq, 32'h20);
        stepTo(w + 40); checkOutput("pre_rst_ovr", 32'(overrun), 32'h2);
        reset = 1'b1;
        stepTo(edgeNum + 1);
        checkOutput("mid_rst_irq", irq, 32'h0);
        checkOutput("mid_rst_ovr", 32'(overrun), 32'h0);
        checkOutput("mid_rst_irq3", 32'(irq3), 32'h0);
        reset   = 1'b0;
        edgeNum = 0;

        // Channel 3 does not exist in the 3-channel instance: write must be ignored
        cfg3We     = 1'b1;
        cfg3Ch     = 2'd3;
        cfg3Period = 8'd0;
        cfg3Mode   = 1'b1;
        cfg3En     = 1'b0;
        stepTo(1);
        cfg3We = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            stepTo(e);
            exp3 = {4'b0000, (e % 5 == 0), (e % 4 == 0), (e % 3 == 0), 1'b0};
            checkOutput($sformatf("bad_ch_e%0d", e), 32'(irq3), 32'(exp3));
        end
        checkOutput("bad_ch_ovr", 32'(overrun3), 32'h0);

        stepTo(8191); checkOutput("post_rst_8191", irq, 32'h0);
        stepTo(8192); checkOutput("post_rst_8192", irq, 32'h10);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
